mgmt_rx_frame_fifo: RTL and testbench

Single-clock, parametrised packet FIFO for received management Ethernet frames, with a companion frame-length header queue.
- Frames are written speculatively and become visible to the reader only on commit. Upstream drop, oversize and no-space conditions roll the frame back.
- Generalises the earlier fixed 32-bit/4096-deep management RX FIFO: parametrised width, depth, header depth and MTU; configurable oversize limit; status outputs.
- Sits between the MAC RX path and the QSPI/CPU register bridge, where both are already in the same clock domain.

---
 rtl/mgmt_rx_frame_fifo.sv | 164 ++++++++++++++++
 tb/tb_mgmt_rx_frame_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_rx_frame_fifo.sv
// Speculative-write packet FIFO for received management frames, plus a frame-length header queue.
// Define MGMT_RX_FIFO_STATS_EN to build the stat_* counters; otherwise those ports read 0.
module mgmt_rx_frame_fifo #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DEPTH           = 4096,
    parameter int unsigned HDR_DEPTH       = 32,
    parameter int unsigned MAX_FRAME_BYTES = 1500,
    parameter int unsigned LEN_WIDTH       = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          link_up,
    input  logic                          rx_start,
    input  logic                          rx_data_valid,
    input  logic [$clog2(DATA_WIDTH/8):0] rx_bytes_valid,
    input  logic [DATA_WIDTH-1:0]         rx_data,
    input  logic                          rx_commit,
    input  logic                          rx_drop,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_empty,
    input  logic                          hdr_rd_en,
    output logic [LEN_WIDTH-1:0]          hdr_rd_data,
    output logic                          hdr_rd_empty,
    output logic [$clog2(DEPTH):0]        wr_free,
    output logic [31:0]                   stat_frames,
    output logic [31:0]                   stat_drop_nospace,
    output logic [31:0]                   stat_drop_oversize,
    output logic [31:0]                   stat_drop_upstream
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned PW        = AW + 1;
    localparam int unsigned HAW       = $clog2(HDR_DEPTH);
    localparam int unsigned HPW       = HAW + 1;
    localparam int unsigned SW        = LEN_WIDTH + 1;
    localparam int unsigned BPW       = DATA_WIDTH / 8;
    localparam int unsigned MAX_WORDS = (MAX_FRAME_BYTES + BPW - 1) / BPW;

    localparam logic [PW-1:0]  DEPTH_P     = PW'(DEPTH);
    localparam logic [PW-1:0]  MAX_WORDS_P = PW'(MAX_WORDS);
    localparam logic [HPW-1:0] HDR_DEPTH_P = HPW'(HDR_DEPTH);
    localparam logic [SW-1:0]  MAX_LEN_P   = SW'(MAX_FRAME_BYTES);

    logic [DATA_WIDTH-1:0] mem     [DEPTH];
    logic [LEN_WIDTH-1:0]  hdr_mem [HDR_DEPTH];

    logic [PW-1:0]        wr_ptr_q, commit_ptr_q, rd_ptr_q;
    logic [HPW-1:0]       hdr_wp_q, hdr_rp_q;
    logic [LEN_WIDTH-1:0] framelen_q;
    logic                 dropping_q;

    logic                 hdr_full, start_ok, drop_s, over_hit, beat_wr, drop_b, commit_hit;
    logic                 rd_fire, hdr_pop;
    logic [PW-1:0]        wp_s, wp_b;
    logic [LEN_WIDTH-1:0] len_s, len_b;
    logic [SW-1:0]        len_sum;

    assign wr_free      = DEPTH_P - (wr_ptr_q - rd_ptr_q);
    assign rd_empty     = (rd_ptr_q == commit_ptr_q);
    assign hdr_rd_empty = (hdr_wp_q == hdr_rp_q);
    assign hdr_full     = ((hdr_wp_q - hdr_rp_q) == HDR_DEPTH_P);
    assign hdr_rd_data  = hdr_rd_empty ? '0 : hdr_mem[hdr_rp_q[HAW-1:0]];
    assign rd_fire      = rd_en && !rd_empty;
    assign hdr_pop      = hdr_rd_en && !hdr_rd_empty;

    // Frame state is resolved in order: start, then the beat, then commit/drop.
    always_comb begin
        start_ok = (wr_free >= MAX_WORDS_P) && !hdr_full;
        drop_s   = dropping_q;
        len_s    = framelen_q;
        wp_s     = wr_ptr_q;
        if (rx_start) begin
            drop_s = !start_ok;
            len_s  = '0;
            wp_s   = commit_ptr_q;
        end
        len_sum    = {1'b0, len_s} + SW'(rx_bytes_valid);
        over_hit   = rx_data_valid && !drop_s && (len_sum > MAX_LEN_P);
        beat_wr    = rx_data_valid && !drop_s && !over_hit;
        drop_b     = drop_s || over_hit;
        wp_b       = over_hit ? commit_ptr_q : wp_s + PW'(beat_wr);
        len_b      = beat_wr ? len_sum[LEN_WIDTH-1:0] : len_s;
        commit_hit = rx_commit && !rx_drop && !drop_b && (len_b != '0);
    end

    always_ff @(posedge clk) begin
        if (link_up && beat_wr) begin
            mem[wp_s[AW-1:0]] <= rx_data;
        end
        if (link_up && commit_hit) begin
            hdr_mem[hdr_wp_q[HAW-1:0]] <= len_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            hdr_wp_q     <= '0;
            hdr_rp_q     <= '0;
            framelen_q   <= '0;
            dropping_q   <= 1'b1;
            rd_data      <= '0;
        end else if (!link_up) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            hdr_wp_q     <= '0;
            hdr_rp_q     <= '0;
            framelen_q   <= '0;
            dropping_q   <= 1'b1;
        end else begin
            wr_ptr_q   <= rx_drop ? commit_ptr_q : wp_b;
            framelen_q <= len_b;
            dropping_q <= drop_b || rx_drop || commit_hit;
            if (commit_hit) begin
                commit_ptr_q <= wp_b;
                hdr_wp_q     <= hdr_wp_q + HPW'(1);
            end
            if (rd_fire) begin
                rd_data  <= mem[rd_ptr_q[AW-1:0]];
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (hdr_pop) begin
                hdr_rp_q <= hdr_rp_q + HPW'(1);
            end
        end
    end

`ifdef MGMT_RX_FIFO_STATS_EN
    logic inc_frames, inc_nospace, inc_oversize, inc_upstream;

    // A flush discards the frame in flight without counting it.
    assign inc_frames   = link_up && commit_hit;
    assign inc_nospace  = link_up && rx_start && !start_ok;
    assign inc_oversize = link_up && over_hit;
    assign inc_upstream = link_up && rx_drop && !drop_b;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames        <= '0;
            stat_drop_nospace  <= '0;
            stat_drop_oversize <= '0;
            stat_drop_upstream <= '0;
        end else begin
            stat_frames        <= sat_inc(stat_frames, inc_frames);
            stat_drop_nospace  <= sat_inc(stat_drop_nospace, inc_nospace);
            stat_drop_oversize <= sat_inc(stat_drop_oversize, inc_oversize);
            stat_drop_upstream <= sat_inc(stat_drop_upstream, inc_upstream);
        end
    end
`else
    assign stat_frames        = '0;
    assign stat_drop_nospace  = '0;
    assign stat_drop_oversize = '0;
    assign stat_drop_upstream = '0;
`endif

endmodule

// File: tb/tb_mgmt_rx_frame_fifo.sv
// Randomised scoreboard bench for mgmt_rx_frame_fifo: frame-level model drives expectations,
// a negedge monitor pops and compares read data and header entries.
module tb_mgmt_rx_frame_fifo;
    localparam int DW        = 32;
    localparam int DEPTH     = 4096;
    localparam int HDR_DEPTH = 32;
    localparam int MAX_BYTES = 1500;
    localparam int LW        = 11;
    localparam int BPW       = DW / 8;
    localparam int MAX_WORDS = (MAX_BYTES + BPW - 1) / BPW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          link_up = 1'b1;
    logic          rx_start = 1'b0;
    logic          rx_data_valid = 1'b0;
    logic [2:0]    rx_bytes_valid = '0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_commit = 1'b0;
    logic          rx_drop = 1'b0;
    logic          rd_en = 1'b0;
    logic          hdr_rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_empty;
    logic [LW-1:0] hdr_rd_data;
    logic          hdr_rd_empty;
    logic [12:0]   wr_free;
    logic [31:0]   stat_frames, stat_drop_nospace, stat_drop_oversize, stat_drop_upstream;

    int checks = 0;
    int errors = 0;
    int m_occ = 0, m_hdr = 0;
    int m_frames = 0, m_nospace = 0, m_over = 0, m_up = 0;
    logic [DW-1:0] exp_data[$];
    int            exp_hdr[$];
    bit            pend_rd = 1'b0;

    mgmt_rx_frame_fifo #(
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .HDR_DEPTH      (HDR_DEPTH),
        .MAX_FRAME_BYTES(MAX_BYTES),
        .LEN_WIDTH      (LW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .link_up           (link_up),
        .rx_start          (rx_start),
        .rx_data_valid     (rx_data_valid),
        .rx_bytes_valid    (rx_bytes_valid),
        .rx_data           (rx_data),
        .rx_commit         (rx_commit),
        .rx_drop           (rx_drop),
        .rd_en             (rd_en),
        .rd_data           (rd_data),
        .rd_empty          (rd_empty),
        .hdr_rd_en         (hdr_rd_en),
        .hdr_rd_data       (hdr_rd_data),
        .hdr_rd_empty      (hdr_rd_empty),
        .wr_free           (wr_free),
        .stat_frames       (stat_frames),
        .stat_drop_nospace (stat_drop_nospace),
        .stat_drop_oversize(stat_drop_oversize),
        .stat_drop_upstream(stat_drop_upstream)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT presented output with no expected entry queued", name);
    endtask

    function automatic longint sx(input int v);
`ifdef MGMT_RX_FIFO_STATS_EN
        return longint'(v);
`else
        return 0;
`endif
    endfunction

    // Monitor: reads issued at one negedge are compared at the next; headers are FWFT.
    always @(negedge clk) begin
        if (pend_rd) begin
            pend_rd = 1'b0;
            if (exp_data.size() == 0) fail_now("rd_data_extra");
            else chk("rd_data", rd_data, exp_data.pop_front());
        end
        if (rst_n && link_up && rd_en && !rd_empty) pend_rd = 1'b1;
        if (rst_n && link_up && hdr_rd_en && !hdr_rd_empty) begin
            if (exp_hdr.size() == 0) fail_now("hdr_extra");
            else chk("hdr_rd_data", hdr_rd_data, exp_hdr.pop_front());
        end
    end

    task automatic step(input int rd_pct, input int hdr_pct);
        bit r, h;
        chk("rd_empty", rd_empty, (m_occ == 0));
        chk("hdr_rd_empty", hdr_rd_empty, (m_hdr == 0));
        r = (m_occ > 0) && ($urandom_range(0, 99) < rd_pct);
        h = (m_hdr > 0) && ($urandom_range(0, 99) < hdr_pct);
        rd_en = r;
        hdr_rd_en = h;
        @(posedge clk);
        #1;
        if (r) m_occ--;
        if (h) m_hdr--;
        rx_start = 1'b0;
        rx_data_valid = 1'b0;
        rx_commit = 1'b0;
        rx_drop = 1'b0;
        rd_en = 1'b0;
        hdr_rd_en = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_wr_free"}, wr_free, DEPTH - m_occ);
        chk({tag, "_stat_frames"}, stat_frames, sx(m_frames));
        chk({tag, "_stat_nospace"}, stat_drop_nospace, sx(m_nospace));
        chk({tag, "_stat_oversize"}, stat_drop_oversize, sx(m_over));
        chk({tag, "_stat_upstream"}, stat_drop_upstream, sx(m_up));
    endtask

    task automatic send_frame(input int len, input bit do_drop, input int rd_pct,
                              input int hdr_pct);
        int            nb, rem;
        bit            acc, ended;
        logic [DW-1:0] w;
        logic [DW-1:0] wq[$];
        nb = (len + BPW - 1) / BPW;
        acc = (DEPTH - m_occ >= MAX_WORDS) && (m_hdr < HDR_DEPTH);
        ended = 1'b0;
        rx_start = 1'b1;
        if (nb == 0 || $urandom_range(0, 1) == 0) step(rd_pct, hdr_pct);
        for (int b = 0; b < nb; b++) begin
            if (b > 0 && $urandom_range(0, 3) == 0) step(rd_pct, hdr_pct);
            w = $urandom;
            wq.push_back(w);
            rem = len - b * BPW;
            rx_data_valid = 1'b1;
            rx_data = w;
            rx_bytes_valid = 3'((rem >= BPW) ? BPW : rem);
            if (b == nb - 1 && $urandom_range(0, 1) == 1) begin
                rx_commit = !do_drop;
                rx_drop = do_drop;
                ended = 1'b1;
            end
            step(rd_pct, hdr_pct);
        end
        if (!ended) begin
            rx_commit = !do_drop;
            rx_drop = do_drop;
            step(rd_pct, hdr_pct);
        end
        if (!acc) m_nospace++;
        else if (len > MAX_BYTES) m_over++;
        else if (do_drop) m_up++;
        else if (len > 0) begin
            foreach (wq[i]) exp_data.push_back(wq[i]);
            exp_hdr.push_back(len);
            m_occ += nb;
            m_hdr++;
            m_frames++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_occ > 0 || m_hdr > 0) && n < 10000) begin
            step(100, 100);
            n++;
        end
        chk("drain_done", m_occ + m_hdr, 0);
    endtask

    initial begin
        int free0, len, r;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_empty", rd_empty, 1);
        chk("rst_hdr_rd_empty", hdr_rd_empty, 1);
        chk("rst_hdr_rd_data", hdr_rd_data, 0);
        check_idle("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_frame(64, 1'b0, 0, 0);
        chk("hdr_head_64", hdr_rd_data, 64);
        check_idle("f64");
        drain();

        send_frame(1501, 1'b0, 0, 0);
        chk("oversize_no_hdr", hdr_rd_empty, 1);
        check_idle("oversize");
        send_frame(100, 1'b0, 0, 0);
        chk("hdr_head_100", hdr_rd_data, 100);
        check_idle("f100");
        drain();

        send_frame(0, 1'b0, 0, 0);
        chk("zero_len_no_hdr", hdr_rd_empty, 1);
        check_idle("zero");

        free0 = DEPTH - m_occ;
        for (int b = 0; b < 40; b++) begin
            rx_start = (b == 0);
            rx_data_valid = 1'b1;
            rx_data = $urandom;
            rx_bytes_valid = 3'(BPW);
            step(0, 0);
        end
        chk("wr_free_inflight", wr_free, free0 - 40);
        rx_drop = 1'b1;
        step(0, 0);
        m_up++;
        chk("wr_free_after_drop", wr_free, free0);
        chk("rd_empty_after_drop", rd_empty, 1);
        check_idle("drop40");

        for (int i = 0; i < 11; i++) send_frame(1500, 1'b0, 0, 0);
        check_idle("fill");
        drain();

        for (int i = 0; i < 33; i++) send_frame(60, 1'b0, 0, 0);
        check_idle("hdrfull");
        for (int i = 0; i < 15; i++) step(100, (i == 0) ? 100 : 0);
        send_frame(60, 1'b0, 0, 0);
        check_idle("hdrfree");
        drain();

        for (int i = 0; i < 3; i++) send_frame($urandom_range(40, 200), 1'b0, 0, 0);
        for (int b = 0; b < 5; b++) begin
            rx_start = (b == 0);
            rx_data_valid = 1'b1;
            rx_data = $urandom;
            rx_bytes_valid = 3'(BPW);
            step(0, 0);
        end
        link_up = 1'b0;
        step(0, 0);
        m_occ = 0;
        m_hdr = 0;
        exp_data.delete();
        exp_hdr.delete();
        chk("flush_rd_empty", rd_empty, 1);
        chk("flush_hdr_empty", hdr_rd_empty, 1);
        check_idle("flush");
        link_up = 1'b1;
        step(0, 0);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7) len = $urandom_range(1, 256);
            else if (r < 9) len = $urandom_range(1450, 1520);
            else len = $urandom_range(1, 12);
            send_frame(len, ($urandom_range(0, 9) == 0), 50, 30);
            check_idle("rand");
        end
        drain();
        step(0, 0);
        step(0, 0);
        chk("exp_data_left", exp_data.size(), 0);
        chk("exp_hdr_left", exp_hdr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
